// File: rtl/rf_cmd_sequencer_if.sv
// Command, register-file, ALU and response signals of the command sequencer.
// slave is the sequencer side; master is the host / datapath environment side.
interface rf_cmd_sequencer_if #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int OPW = 4
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_op;
  logic [AW-1:0]  cmd_rs1;
  logic [AW-1:0]  cmd_rs2;
  logic [AW-1:0]  cmd_rd;
  logic           cmd_we;

  logic [AW-1:0]  r1_addr;
  logic [AW-1:0]  r2_addr;
  logic [DW-1:0]  r1_out;
  logic [DW-1:0]  r2_out;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  ALU_A;
  logic [DW-1:0]  ALU_B;
  logic [DW-1:0]  ALU_OUT;

  logic [AW-1:0]  r3_addr;
  logic           r3_we;
  logic [DW-1:0]  r3_in;

  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic [AW-1:0]  rsp_rd;
  logic           busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_we,
    input  r1_out, r2_out, ALU_OUT,
    output cmd_ready, r1_addr, r2_addr, alu_op, ALU_A, ALU_B,
    output r3_addr, r3_we, r3_in, rsp_valid, rsp_data, rsp_rd, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_we,
    output r1_out, r2_out, ALU_OUT,
    input  cmd_ready, r1_addr, r2_addr, alu_op, ALU_A, ALU_B,
    input  r3_addr, r3_we, r3_in, rsp_valid, rsp_data, rsp_rd, busy
  );
endinterface

// File: rtl/rf_cmd_sequencer.sv
// Buffers register-to-register commands in a FIFO and runs each through a fixed
// IDLE/READ/EXEC/WRITE schedule (4 cycles per command); cmd_ready = count < DEPTH.
module rf_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_cmd_sequencer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rs1;
    logic [AW-1:0]  rs2;
    logic [AW-1:0]  rd;
    logic           we;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  cmd_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  cmd_t          cmd_in;
  cmd_t          cur;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_nxt;

  // Ready looks only at occupancy, so a full FIFO refuses even on a pop cycle.
  assign bus.cmd_ready = (count < DEPTH_C);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign bus.busy      = (state != IDLE) || (count != '0);

  assign cmd_in.op  = bus.cmd_op;
  assign cmd_in.rs1 = bus.cmd_rs1;
  assign cmd_in.rs2 = bus.cmd_rs2;
  assign cmd_in.rd  = bus.cmd_rd;
  assign cmd_in.we  = bus.cmd_we;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = READ;
        end
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Operand/result registers hold between commands; only r3_we and rsp_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur           <= '0;
      bus.r1_addr   <= '0;
      bus.r2_addr   <= '0;
      bus.alu_op    <= '0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.r3_addr   <= '0;
      bus.r3_in     <= '0;
      bus.r3_we     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_rd    <= '0;
    end else begin
      bus.r3_we     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur         <= fifo_mem[rd_ptr];
            bus.r1_addr <= fifo_mem[rd_ptr].rs1;
            bus.r2_addr <= fifo_mem[rd_ptr].rs2;
          end
        end
        READ: begin
          bus.ALU_A  <= bus.r1_out;
          bus.ALU_B  <= bus.r2_out;
          bus.alu_op <= cur.op;
        end
        EXEC: begin
          bus.r3_addr   <= cur.rd;
          bus.r3_in     <= bus.ALU_OUT;
          bus.r3_we     <= cur.we;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= bus.ALU_OUT;
          bus.rsp_rd    <= cur.rd;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/rf_cmd_sequencer.md
# rf_cmd_sequencer

Command-driven sequencer for the register-file/ALU datapath. It accepts register-to-register operations (op, rs1, rs2, rd) through a valid/ready port and buffers them in a small FIFO. Each command then runs through a fixed READ → EXEC → WRITE schedule that drives the register-file read ports, the ALU operands and the register-file write port. It replaces hard-wired fill sequencing with a general scheduler that the host or a test FSM feeds.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- AW, 5, register address width
- DW, 32, data width
- OPW, 4, ALU opcode width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (count < DEPTH)
- cmd_op  in  OPW  ALU operation
- cmd_rs1 / cmd_rs2  in  AW  source registers
- cmd_rd  in  AW  destination register
- cmd_we  in  1  write result back to rd
- r1_addr / r2_addr  out  AW  register-file read addresses (registered)
- r1_out / r2_out  in  DW  register-file read data (combinational from address)
- alu_op  out  OPW  ALU opcode (registered)
- ALU_A / ALU_B  out  DW  ALU operands (registered)
- ALU_OUT  in  DW  ALU result (combinational)
- r3_addr  out  AW  write address
- r3_we  out  1  write enable, one-cycle pulse
- r3_in  out  DW  write data
- rsp_valid  out  1  command-complete pulse
- rsp_data  out  DW  result of completed command
- rsp_rd  out  AW  rd of completed command
- busy  out  1  state ≠ IDLE or FIFO not empty

## Operation
- FIFO
  - Push on cmd_valid & cmd_ready. Stored fields: {op, rs1, rs2, rd, we}.
  - cmd_ready = (count < DEPTH). It does not depend on a same-cycle pop, so a full FIFO stalls for one cycle even while popping.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: if count > 0, pop the head into the current-command register, load r1_addr/r2_addr from rs1/rs2, go to READ. Otherwise stay in IDLE.
  - READ: ALU_A ← r1_out, ALU_B ← r2_out, alu_op ← op; go to EXEC.
  - EXEC: result ← ALU_OUT, full DW, no truncation or extension. Set r3_addr ← rd, r3_in ← ALU_OUT, r3_we ← we, rsp_valid ← 1, rsp_data ← ALU_OUT, rsp_rd ← rd. Go to WRITE.
  - WRITE: r3_we and rsp_valid are high for this single cycle. At the end of the cycle, clear both and go to IDLE.
- When cmd_we = 0, no register write occurs (r3_we stays 0), but the rsp_valid pulse is still issued.
- ALU_A, ALU_B, r3_in and rsp_data hold their last values between commands. Only r3_we and rsp_valid are pulses.
- No RAW hazard exists by construction. A write commits at the edge that leaves WRITE, and the next command's addresses are registered at or after that edge, so its READ cycle sees the new value.

## Timing
- Reset values:
  - State IDLE; FIFO empty, pointers 0.
  - cmd_ready = 1 in the cycle after reset; busy = 0.
  - r1_addr, r2_addr, r3_addr, alu_op, ALU_A, ALU_B, r3_in, rsp_data and rsp_rd = 0.
  - r3_we = 0, rsp_valid = 0.
- Latency, with the command accepted at edge E0 and the FIFO empty and IDLE:
  - E1: pop; addresses valid.
  - E2: operands registered.
  - E3: r3_we and rsp_valid rise.
  - E4: register file written; pulses fall.
- Throughput: one command per 4 cycles (IDLE, READ, EXEC, WRITE). IDLE is always visited.
- Reset mid-operation:
  - The in-flight command is discarded and the FIFO is flushed.
  - r3_we is 0 from the first post-reset cycle, so no partial write occurs.
- rst asserted in the same cycle as a push: reset wins and the command is not stored.

## Test plan
- Single command:
  - Setup: regs r0 = 1, r1 = 1.
  - Stimulus: push {add, rs1=0, rs2=1, rd=2, we=1}.
  - Required: r1_addr = 0 and r2_addr = 1 at E1. ALU_A = 1 and ALU_B = 1 at E2. r3_we = 1, r3_addr = 2, r3_in = 2 and rsp_valid = 1 for exactly one cycle after E3.
- Dependent chain (Fibonacci):
  - Stimulus: push r2 = r0 + r1, r3 = r1 + r2, r4 = r2 + r3 back-to-back.
  - Required: writes of 2, 3, 5 spaced 4 cycles apart, with no stale operands.
- Backpressure:
  - Stimulus: hold cmd_valid for 6 commands while the FSM is busy.
  - Required: cmd_ready drops after DEPTH = 4 stored, and is re-asserted the cycle after the first pop. All 6 commands complete in push order.
- No-writeback:
  - Stimulus: push {we=0, rd=5} with rs values 7 and 3 (add).
  - Required: rsp_valid pulses with rsp_data = 10; r3_we stays 0; r5 unchanged.
- Reset in WRITE:
  - Stimulus: assert rst during the WRITE cycle with 2 commands queued.
  - Required: r3_we = 0 and rsp_valid = 0 next cycle; busy = 0; the queued commands never execute.
- Push/pop same cycle:
  - Stimulus: count = 2, push while the FSM pops.
  - Required: count stays 2 and order is preserved. Repeat across pointer wrap (≥ 2·DEPTH commands) with no loss or duplication.
